// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: six RW control registers, a live read-only status
// word and a write-one-to-clear interrupt register. Write address and write
// data are accepted independently; one write and one read may be outstanding.
module axil_reg_slave #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_ARESET,
  // write address channel
  input  logic [C_AXI_ADDR_WIDTH-1:0]     AXI_AWADDR,
  input  logic [2:0]                      AXI_AWPROT,
  input  logic                            AXI_AWVALID,
  output logic                            AXI_AWREADY,
  // write data channel
  input  logic [C_AXI_DATA_WIDTH-1:0]     AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   AXI_WSTRB,
  input  logic                            AXI_WVALID,
  output logic                            AXI_WREADY,
  // write response channel
  output logic [1:0]                      AXI_BRESP,
  output logic                            AXI_BVALID,
  input  logic                            AXI_BREADY,
  // read address channel
  input  logic [C_AXI_ADDR_WIDTH-1:0]     AXI_ARADDR,
  input  logic [2:0]                      AXI_ARPROT,
  input  logic                            AXI_ARVALID,
  output logic                            AXI_ARREADY,
  // read data channel
  output logic [C_AXI_DATA_WIDTH-1:0]     AXI_RDATA,
  output logic [1:0]                      AXI_RRESP,
  output logic                            AXI_RVALID,
  input  logic                            AXI_RREADY,
  // register fabric side
  output logic [6*C_AXI_DATA_WIDTH-1:0]   REGS_OUT,
  input  logic [C_AXI_DATA_WIDTH-1:0]     STATUS_IN,
  input  logic [C_AXI_DATA_WIDTH-1:0]     IRQ_SET,
  output logic                            IRQ
);

  localparam int DW     = C_AXI_DATA_WIDTH;
  localparam int SW     = C_AXI_DATA_WIDTH / 8;
  localparam int NUM_RW = 6;
  // Word index: byte address with the two lane-select bits dropped.
  localparam int IDX_W  = C_AXI_ADDR_WIDTH - 2;

  localparam logic [IDX_W-1:0] IDX_NUM_RW = IDX_W'(NUM_RW);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(6);
  localparam logic [IDX_W-1:0] IDX_IRQ    = IDX_W'(7);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             ready_en_reg;
  logic             aw_held_reg;
  logic [IDX_W-1:0] aw_idx_reg;
  logic             w_held_reg;
  logic [DW-1:0]    w_data_reg;
  logic [SW-1:0]    w_strb_reg;
  logic             bvalid_reg;
  logic [1:0]       bresp_reg;
  logic             rvalid_reg;
  logic [1:0]       rresp_reg;
  logic [DW-1:0]    rdata_reg;
  logic [DW-1:0]    regs_reg [0:NUM_RW-1];
  logic [DW-1:0]    irq_reg;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic             awready;
  logic             wready;
  logic             arready;
  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             commit;
  logic [IDX_W-1:0] cm_idx;
  logic [DW-1:0]    cm_data;
  logic [SW-1:0]    cm_strb;
  logic [DW-1:0]    cm_mask;
  logic             cm_is_rw;
  logic             cm_is_status;
  logic             cm_is_irq;
  logic [1:0]       bresp_next;
  logic [NUM_RW-1:0] rw_wr_en;
  logic [DW-1:0]    irq_clear;
  logic [DW-1:0]    irq_next;
  logic [IDX_W-1:0] rd_idx;
  logic [DW-1:0]    rdata_next;
  logic [1:0]       rresp_next;
  logic             sig_unused;

  // Protection bits and byte-lane address bits carry no meaning here.
  assign sig_unused = ^{AXI_AWPROT, AXI_ARPROT, AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

  // Readies are gated by reset so they read 0 for the whole reset period,
  // including the cycle in which reset is first raised.
  assign awready = ready_en_reg & ~AXI_ARESET & ~aw_held_reg & ~bvalid_reg;
  assign wready  = ready_en_reg & ~AXI_ARESET & ~w_held_reg  & ~bvalid_reg;
  assign arready = ready_en_reg & ~AXI_ARESET & ~rvalid_reg;

  assign aw_hs = AXI_AWVALID & awready;
  assign w_hs  = AXI_WVALID  & wready;
  assign ar_hs = AXI_ARVALID & arready;

  // A channel counts as "held" either from its latch or from a handshake in
  // this very cycle, so same-cycle AW+W commits without an extra wait state.
  assign commit  = (aw_held_reg | aw_hs) & (w_held_reg | w_hs);
  assign cm_idx  = aw_hs ? AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2] : aw_idx_reg;
  assign cm_data = w_hs  ? AXI_WDATA : w_data_reg;
  assign cm_strb = w_hs  ? AXI_WSTRB : w_strb_reg;

  // Expand byte strobes into a bit mask.
  generate
    for (genvar gi = 0; gi < SW; gi++) begin : g_strb_mask
      assign cm_mask[gi*8 +: 8] = {8{cm_strb[gi]}};
    end
  endgenerate

  assign cm_is_rw     = (cm_idx < IDX_NUM_RW);
  assign cm_is_status = (cm_idx == IDX_STATUS);
  assign cm_is_irq    = (cm_idx == IDX_IRQ);
  assign bresp_next   = (cm_is_rw | cm_is_status | cm_is_irq) ? RESP_OKAY : RESP_SLVERR;

  // One write enable per RW register.
  generate
    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_wr_en
      assign rw_wr_en[gi] = commit & (cm_idx == IDX_W'(gi));
    end
  endgenerate

  // W1C clear vector; IRQ_SET has priority over a clear of the same bit.
  assign irq_clear = (commit & cm_is_irq) ? (cm_data & cm_mask) : '0;
  assign irq_next  = IRQ_SET | (irq_reg & ~irq_clear);

  assign rd_idx = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];

  // Read mux: selects the current (pre-commit) value of the addressed source.
  always_comb begin
    rdata_next = '0;
    rresp_next = RESP_SLVERR;
    if (rd_idx < IDX_NUM_RW) begin
      rresp_next = RESP_OKAY;
      for (int i = 0; i < NUM_RW; i++) begin
        if (rd_idx == IDX_W'(i)) begin
          rdata_next = regs_reg[i];
        end
      end
    end else if (rd_idx == IDX_STATUS) begin
      rdata_next = STATUS_IN;
      rresp_next = RESP_OKAY;
    end else if (rd_idx == IDX_IRQ) begin
      rdata_next = irq_reg;
      rresp_next = RESP_OKAY;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Enables the readies from the first cycle after reset is released.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
    end
  end

  // Latch the write address until the commit consumes it.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      aw_held_reg <= 1'b0;
      aw_idx_reg  <= '0;
    end else if (commit) begin
      aw_held_reg <= 1'b0;
    end else if (aw_hs) begin
      aw_held_reg <= 1'b1;
      aw_idx_reg  <= AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
    end
  end

  // Latch the write data and strobes until the commit consumes them.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      w_held_reg <= 1'b0;
      w_data_reg <= '0;
      w_strb_reg <= '0;
    end else if (commit) begin
      w_held_reg <= 1'b0;
    end else if (w_hs) begin
      w_held_reg <= 1'b1;
      w_data_reg <= AXI_WDATA;
      w_strb_reg <= AXI_WSTRB;
    end
  end

  // Write response: raised by the commit, held until BREADY.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      bvalid_reg <= 1'b0;
      bresp_reg  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_reg <= 1'b1;
      bresp_reg  <= bresp_next;
    end else if (bvalid_reg && AXI_BREADY) begin
      bvalid_reg <= 1'b0;
    end
  end

  // RW register file with per-byte write strobes.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      for (int i = 0; i < NUM_RW; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (rw_wr_en[i]) begin
          regs_reg[i] <= (regs_reg[i] & ~cm_mask) | (cm_data & cm_mask);
        end
      end
    end
  end

  // Interrupt register: sticky set, write-one-to-clear.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      irq_reg <= '0;
    end else begin
      irq_reg <= irq_next;
    end
  end

  // Read response: captured at the AR handshake, held until RREADY.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rdata_next;
      rresp_reg  <= rresp_next;
    end else if (rvalid_reg && AXI_RREADY) begin
      rvalid_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign AXI_AWREADY = awready;
  assign AXI_WREADY  = wready;
  assign AXI_ARREADY = arready;
  assign AXI_BVALID  = bvalid_reg;
  assign AXI_BRESP   = bresp_reg;
  assign AXI_RVALID  = rvalid_reg;
  assign AXI_RDATA   = rdata_reg;
  assign AXI_RRESP   = rresp_reg;
  assign IRQ         = |irq_reg;

  generate
    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_regs_out
      assign REGS_OUT[gi*DW +: DW] = regs_reg[gi];
    end
  endgenerate

endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 Parameter: C_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
REQ-002 Parameter: C_AXI_ADDR_WIDTH, 8, byte address width.
REQ-003 One clock and a synchronous, active-high reset.
REQ-004 AXI_ACLK  in  1  clock; all logic on rising edge.
REQ-005 AXI_ARESET  in  1  synchronous active-high reset.
REQ-006 AXI_AWADDR/AXI_AWPROT/AXI_AWVALID  in  8/3/1; AXI_AWREADY  out  1: write address channel; AWPROT is ignored.
REQ-007 AXI_WDATA/AXI_WSTRB/AXI_WVALID  in  32/4/1; AXI_WREADY  out  1: write data channel.
REQ-008 AXI_BRESP/AXI_BVALID  out  2/1; AXI_BREADY  in  1: write response channel.
REQ-009 AXI_ARADDR/AXI_ARPROT/AXI_ARVALID  in  8/3/1; AXI_ARREADY  out  1: read address channel; ARPROT is ignored.
REQ-010 AXI_RDATA/AXI_RRESP/AXI_RVALID  out  32/2/1; AXI_RREADY  in  1: read data channel.
REQ-011 REGS_OUT  out  192  contents of registers 0-5, with reg0 at bits [31:0].
REQ-012 STATUS_IN  in  32  live status word, read-only at 0x18.
REQ-013 IRQ_SET  in  32  per-bit set pulses for IRQ register.
REQ-014 IRQ  out  1  OR-reduction of the IRQ register.

Function
REQ-015 Map (byte address, bits [1:0] ignored): 0x00-0x14 reg0-reg5 RW; 0x18 STATUS RO; 0x1C IRQ W1C; 0x20-0xFF unmapped.
REQ-016 Write path: the AW and W channels are accepted independently, in either order or in the same cycle; each is latched on its handshake.
REQ-017 After its handshake, AWREADY (resp. WREADY) stays low until the matching B handshake completes.
REQ-018 Commit happens on the clock edge at which both AW and W are held. The register updates at that edge and BVALID=1 from the next cycle.
REQ-019 RW write is per-byte: byte i is updated only when WSTRB[i]=1. WSTRB=0 writes nothing and returns OKAY.
REQ-020 STATUS write: ignored, BRESP=OKAY (00).
REQ-021 IRQ write: each bit with WDATA=1 under an active strobe is cleared.
REQ-022 Unmapped write: no state change, BRESP=SLVERR (10).
REQ-023 BVALID and BRESP are held stable until BREADY=1. On the B handshake, AWREADY and WREADY return to 1 in the next cycle; at most one write is outstanding.
REQ-024 Read path: ARREADY=1 when idle. On the AR handshake at cycle N, RDATA/RRESP are registered and RVALID=1 from N+1. ARREADY=0 until the R handshake, then returns to 1 the next cycle.
REQ-025 RDATA/RRESP are held stable while RVALID=1 and RREADY=0.
REQ-026 Read sources: RW reg value; STATUS_IN sampled at the AR handshake cycle; IRQ reg value.
REQ-027 Unmapped read: RDATA=0, RRESP=SLVERR.
REQ-028 Read and write channels are fully independent and may be active in the same cycle.
REQ-029 A read handshake in the same cycle as a write commit to the same register returns the pre-write value.
REQ-030 IRQ register update: bit <= IRQ_SET[i] | (bit & ~clear[i]). Set wins over a simultaneous W1C clear.
REQ-031 RRESP/BRESP never take the values 01 (EXOKAY) or 11 (DECERR).

Reset
REQ-032 While AXI_ARESET=1: all registers and IRQ = 0; AWREADY=WREADY=ARREADY=0; BVALID=RVALID=0; BRESP=RRESP=00; RDATA=0; latched AW/W are discarded.
REQ-033 Readies go to 1 in the first cycle after reset deasserts.
REQ-034 Reset asserted mid-transaction aborts the transaction: no pending commit and no response is issued afterwards.

Verification
REQ-035 AW 0x04 and W 0xDEADBEEF with WSTRB 0xF in the same cycle -> BVALID next cycle, BRESP=00; REGS_OUT[63:32]=0xDEADBEEF; read 0x04 returns 0xDEADBEEF, RRESP=00.
REQ-036 Reg0=0x11223344; W (0xAABBCCDD, WSTRB 0x5) three cycles before AW 0x00 -> WREADY low after W, commit on AW; reg0=0x11BB33DD.
REQ-037 Write 0x40 -> BRESP=10 and no register changes; read 0x40 -> RDATA=0, RRESP=10.
REQ-038 IRQ_SET=0x3 for one cycle -> IRQ=1; write 0x1C with 0x1 -> IRQ reg=0x2; IRQ_SET[1]=1 in the same cycle as a W1C of 0x2 -> bit 1 stays 1.
REQ-039 Read 0x18 with RREADY held low 5 cycles while STATUS_IN changes -> RVALID=1 and RDATA stable at the value sampled at the AR handshake; ARREADY=0 throughout.
REQ-040 Reset asserted while BVALID=1 -> BVALID=0, all registers 0, and no B response after release.
